// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: LFSR mole placement, edge-detected hits, saturating score.
// Optional define MOLE_MISS_PENALTY_EN adds a wrong-hole miss strobe and score penalty.
module mole_hit_scorer #(
  parameter int          NUM_MOLES = 8,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 game_in_progress,
  input  logic                 mole_clk,
  input  logic [NUM_MOLES-1:0] hit_switches,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic [SCORE_W-1:0]   score,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);
  typedef enum logic [1:0] {IDLE, ARMED, UP, HIT} state_t;

  state_t               state_q;
  logic [15:0]          lfsr_q;
  logic                 mclk_q, gip_q, hit_q;
  logic [NUM_MOLES-1:0] sw_q, leds_q, sw_rise, leds_d;
  logic [SCORE_W-1:0]   score_q;
  logic [4:0]           prev_q, raw_d, pos_d;
  logic                 lfsr_fb, gip_rise, mclk_rise, good_hit;

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign gip_rise  = game_in_progress & ~gip_q;
  assign mclk_rise = mole_clk & ~mclk_q;
  assign sw_rise   = hit_switches & ~sw_q;
  assign good_hit  = |(sw_rise & leds_q);
  assign raw_d     = {1'b0, lfsr_q[3:0]} % 5'(NUM_MOLES);

  // Never repeat the previous hole: bump by one, wrapping to hole 0.
  always_comb begin
    pos_d = raw_d;
    if (raw_d == prev_q)
      pos_d = (raw_d == 5'(NUM_MOLES - 1)) ? 5'd0 : raw_d + 5'd1;
    leds_d = {{(NUM_MOLES-1){1'b0}}, 1'b1} << pos_d;
  end

`ifdef MOLE_MISS_PENALTY_EN
  logic miss_q, wrong_hit;
  assign wrong_hit  = |(sw_rise & ~leds_q);
  assign miss_pulse = miss_q;
`else
  assign miss_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      mclk_q  <= 1'b0;
      gip_q   <= 1'b0;
      sw_q    <= '0;
      leds_q  <= '0;
      score_q <= '0;
      prev_q  <= '0;
      hit_q   <= 1'b0;
`ifdef MOLE_MISS_PENALTY_EN
      miss_q  <= 1'b0;
`endif
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      mclk_q <= mole_clk;
      gip_q  <= game_in_progress;
      sw_q   <= hit_switches;
      hit_q  <= 1'b0;
`ifdef MOLE_MISS_PENALTY_EN
      miss_q <= 1'b0;
`endif
      if (!game_in_progress) begin
        state_q <= IDLE;
        leds_q  <= '0;
      end else begin
        case (state_q)
          IDLE:
            if (gip_rise) begin
              state_q <= ARMED;
              score_q <= '0;
              prev_q  <= '0;
            end
          ARMED:
            if (mclk_rise) begin
              state_q <= UP;
              leds_q  <= leds_d;
              prev_q  <= pos_d;
            end
          // The mole window closing takes priority over a same-cycle press.
          UP:
            if (!mole_clk) begin
              state_q <= ARMED;
              leds_q  <= '0;
            end else if (good_hit) begin
              state_q <= HIT;
              leds_q  <= '0;
              hit_q   <= 1'b1;
              if (score_q != {SCORE_W{1'b1}}) score_q <= score_q + SCORE_W'(1);
            end
`ifdef MOLE_MISS_PENALTY_EN
            else if (wrong_hit) begin
              miss_q <= 1'b1;
              if (score_q != '0) score_q <= score_q - SCORE_W'(1);
            end
`endif
          HIT:
            if (!mole_clk) state_q <= ARMED;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mole_leds = leds_q;
  assign score     = score_q;
  assign hit_pulse = hit_q;
endmodule

// File: doc/mole_hit_scorer.md
MOLE_HIT_SCORER -- requirements
Module: mole_hit_scorer

Interface
REQ-001 SHALL have parameter NUM_MOLES, 8, number of mole LEDs and hit switches (2..16).
REQ-002 SHALL have parameter SCORE_W, 8, score counter width.
REQ-003 SHALL have parameter LFSR_SEED, 16'hACE1, nonzero 16-bit LFSR reset value.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port game_in_progress  input  1  level from the game FSM; high while a round runs.
REQ-007 SHALL have port mole_clk  input  1  level from the game FSM; high = mole-up window.
REQ-008 SHALL have port hit_switches  input  NUM_MOLES  player switches, pre-synchronised, bit i = hole i.
REQ-009 SHALL have port mole_leds  output  NUM_MOLES  one-hot active mole, all-zero when no mole shown.
REQ-010 SHALL have port score  output  SCORE_W  current round score, unsigned.
REQ-011 SHALL have port hit_pulse  output  1  one-cycle strobe per correct hit.
REQ-012 SHALL have port miss_pulse  output  1  one-cycle strobe per wrong-hole press (macro-dependent).

Function
REQ-013 SHALL register mole_clk, game_in_progress and hit_switches once; rising edge = current high & registered low.
REQ-014 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle while rst_n high.
REQ-015 SHALL implement states IDLE, ARMED, UP, HIT.
REQ-016 IDLE -> ARMED on game_in_progress rising edge; score cleared to 0 in that same transition.
REQ-017 ARMED -> UP on mole_clk rising edge; position = LFSR[3:0] mod NUM_MOLES; if equal to previous position, position+1 wrapping to 0.
REQ-018 mole_leds SHALL show the one-hot position from the cycle after the mole_clk edge register update until leaving UP.
REQ-019 In UP, switch rising edge on the active bit -> score+1 (saturate at 2^SCORE_W-1), hit_pulse for 1 cycle, mole_leds cleared next cycle, state HIT.
REQ-020 UP -> ARMED when mole_clk low (mole escaped), mole_leds cleared, score unchanged; HIT -> ARMED when mole_clk low.
REQ-021 Correct and wrong rising edges in the same cycle: correct hit wins, no miss_pulse, no penalty.
REQ-022 A held switch SHALL NOT score twice; only rising edges count; a switch already high at mole appearance does not score.
REQ-023 Any state -> IDLE when game_in_progress low; mole_leds cleared, score held for display.
REQ-024 Previous position SHALL be retained across moles within a round and reset to 0 on IDLE->ARMED.

Reset
REQ-025 On rst_n low at a clk edge: state IDLE, mole_leds 0, score 0, hit_pulse 0, miss_pulse 0, LFSR = LFSR_SEED, edge registers 0, previous position 0.
REQ-026 Reset mid-round SHALL abandon the mole immediately; no pulse emitted in the reset cycle.

Configuration
REQ-027 Macro MOLE_MISS_PENALTY_EN defined: in UP, a rising edge on any non-active switch -> miss_pulse 1 cycle and score-1 saturating at 0; state unchanged.
REQ-028 Macro undefined: miss_pulse tied 0, wrong presses ignored, no penalty logic synthesised.

Verification
REQ-029 Reset, raise game_in_progress, pulse mole_clk high 10 cycles -> exactly one mole_leds bit set, score 0.
REQ-030 With mole at hole k, press bit k -> hit_pulse once, score 0->1, mole_leds 0 next cycle; hold switch through next mole at k-independent hole -> no extra score.
REQ-031 Score preloaded to 255 via 255 hits (SCORE_W=8), one more hit -> score stays 255, hit_pulse still asserted.
REQ-032 MOLE_MISS_PENALTY_EN defined, score 2, press wrong hole twice then thrice -> miss_pulse each press, score 2->1->0->0; same-cycle correct+wrong press -> score+1, no miss_pulse.
REQ-033 Drop game_in_progress while mole up -> mole_leds 0, state IDLE, score held; raise again -> score 0; 50 consecutive moles -> no two consecutive identical positions.
